// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline register: control-bundle layout,
// default payload layout and the per-slot update action.
package pipe_pkg;

   // Control bundle, packed {mem_to_reg, reg_write, mem_read, mem_write, branch}
   localparam int unsigned CTRL_W       = 5;
   localparam int unsigned CTRL_BR      = 0;
   localparam int unsigned CTRL_MEMWR   = 1;
   localparam int unsigned CTRL_MEMRD   = 2;
   localparam int unsigned CTRL_REGWR   = 3;
   localparam int unsigned CTRL_MEM2REG = 4;

   // Default-configuration payload widths
   localparam int unsigned PAYLOAD_XLEN = 64;
   localparam int unsigned PAYLOAD_RA_W = 5;

   // Payload layout at the default configuration; the stage itself packs the
   // same field order into a flat vector so that its widths stay parametrised.
   typedef struct packed {
      logic [PAYLOAD_XLEN-1:0] pc;
      logic [PAYLOAD_XLEN-1:0] alu_result;
      logic [PAYLOAD_XLEN-1:0] rs2_data;
      logic [PAYLOAD_RA_W-1:0] rd;
      logic [CTRL_W-1:0]       ctrl;
      logic                    zero;
   } exmem_payload_t;

   // Action applied to a storage slot on the next clock edge
   typedef enum logic [1:0] {
      SLOT_HOLD      = 2'd0,
      SLOT_LOAD_EX   = 2'd1,
      SLOT_LOAD_SKID = 2'd2,
      SLOT_CLEAR     = 2'd3
   } slot_op_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// Single payload+valid storage slot with load and clear (clear has priority).
// Clearing zeroes the payload, which guarantees a bubble carries no control bits.
module pipe_skid_slot #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] d_i,
   output logic         valid_o,
   output logic [W-1:0] q_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // Next-state selection: clear beats load, otherwise hold
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = 1'b0;
         data_d  = '0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = d_i;
      end
   end

   // Slot state register with asynchronous reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign q_o     = data_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with valid/ready handshake, flush, bubble insertion,
// resolved branch-taken flag and saturating stall counter.
// Optional feature macro: EXMEM_SKID_EN (one-entry skid buffer, registered ex_ready).
module ex_mem_stage_reg #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned RA_W   = 5,
   parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [XLEN-1:0]   ex_pc,
   input  logic [XLEN-1:0]   ex_alu_result,
   input  logic [XLEN-1:0]   ex_rs2_data,
   input  logic [RA_W-1:0]   ex_rd,
   input  logic [CTRL_W-1:0] ex_ctrl,
   input  logic              ex_zero,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [XLEN-1:0]   mem_pc,
   output logic [XLEN-1:0]   mem_alu_result,
   output logic [XLEN-1:0]   mem_rs2_data,
   output logic [RA_W-1:0]   mem_rd,
   output logic [CTRL_W-1:0] mem_ctrl,
   output logic              mem_zero,
   output logic              mem_branch_taken,
   output logic [CNT_W-1:0]  stall_cnt
);
   import pipe_pkg::*;

   localparam int unsigned PW = 3*XLEN + RA_W + CTRL_W + 1;

   logic [PW-1:0] ex_payload, main_d, main_q;
   logic          main_v, main_load, main_clear, accept;
   slot_op_e      main_op;
   logic [CNT_W-1:0] stall_q, stall_d;

   assign ex_payload = {ex_pc, ex_alu_result, ex_rs2_data, ex_rd, ex_ctrl, ex_zero};
   assign accept     = ex_valid & ex_ready;

`ifdef EXMEM_SKID_EN
   logic          skid_v, skid_load, skid_clear;
   logic [PW-1:0] skid_q;

   // Ready is purely the skid-empty flop, so no path from mem_ready
   assign ex_ready = ~skid_v;

   // Main/skid steering: the skid always drains into main before new input,
   // which keeps instruction order intact
   always_comb begin
      main_op    = SLOT_HOLD;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         main_op    = SLOT_CLEAR;
         skid_clear = 1'b1;
      end else if (!main_v || mem_ready) begin
         if (skid_v) begin
            main_op = SLOT_LOAD_SKID;
            if (accept) skid_load  = 1'b1;
            else        skid_clear = 1'b1;
         end else if (accept) begin
            main_op = SLOT_LOAD_EX;
         end else if (main_v) begin
            main_op = SLOT_CLEAR;
         end
      end else if (accept) begin
         skid_load = 1'b1;
      end
   end

   // Main entry source: skid contents take precedence over fresh input
   always_comb begin
      main_d = (main_op == SLOT_LOAD_SKID) ? skid_q : ex_payload;
   end

   pipe_skid_slot #(.W(PW)) u_skid (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .d_i     (ex_payload),
      .valid_o (skid_v),
      .q_o     (skid_q)
   );
`else
   // Accept whenever the entry is empty or being consumed this cycle
   assign ex_ready = ~main_v | mem_ready;

   // Main entry steering: flush wins, a new op replaces a departing one with no bubble
   always_comb begin
      main_op = SLOT_HOLD;
      main_d  = ex_payload;
      if (flush) begin
         main_op = SLOT_CLEAR;
      end else if (accept) begin
         main_op = SLOT_LOAD_EX;
      end else if (main_v && mem_ready) begin
         main_op = SLOT_CLEAR;
      end
   end
`endif

   // Decode slot action into load/clear strobes
   always_comb begin
      main_load  = (main_op == SLOT_LOAD_EX) || (main_op == SLOT_LOAD_SKID);
      main_clear = (main_op == SLOT_CLEAR);
   end

   pipe_skid_slot #(.W(PW)) u_main (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .load_i  (main_load),
      .clear_i (main_clear),
      .d_i     (main_d),
      .valid_o (main_v),
      .q_o     (main_q)
   );

   assign mem_valid = main_v;
   assign {mem_pc, mem_alu_result, mem_rs2_data, mem_rd, mem_ctrl, mem_zero} = main_q;
   assign mem_branch_taken = main_v & mem_ctrl[CTRL_BR] & mem_zero;

   // Stall counter next state: count stalled cycles, stick at all-ones
   always_comb begin
      stall_d = stall_q;
      if (main_v && !mem_ready && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   // Stall counter register; only reset clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: queue-based reference model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_ex_mem_stage_reg;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned RA_W  = 5;
   localparam int unsigned CTRLW = 5;
   localparam int unsigned CNTW  = 4;
   localparam int unsigned CNT_MAX = (1 << CNTW) - 1;

   logic clk = 1'b0;
   logic rst_n, flush, ex_valid, ex_ready, ex_zero, mem_valid, mem_ready;
   logic mem_zero, mem_branch_taken;
   logic [XLEN-1:0]  ex_pc, ex_alu_result, ex_rs2_data;
   logic [XLEN-1:0]  mem_pc, mem_alu_result, mem_rs2_data;
   logic [RA_W-1:0]  ex_rd, mem_rd;
   logic [CTRLW-1:0] ex_ctrl, mem_ctrl;
   logic [CNTW-1:0]  stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_mem_stage_reg #(
      .XLEN(XLEN), .RA_W(RA_W), .CTRL_W(CTRLW), .CNT_W(CNTW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
      .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_zero(ex_zero),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_pc(mem_pc), .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
      .mem_rd(mem_rd), .mem_ctrl(mem_ctrl), .mem_zero(mem_zero),
      .mem_branch_taken(mem_branch_taken), .stall_cnt(stall_cnt)
   );

   // ---------------- reference model: an ordered queue of held ops ----------------
   typedef struct {
      logic [XLEN-1:0]  pc, alu, rs2;
      logic [RA_W-1:0]  rd;
      logic [CTRLW-1:0] ctrl;
      logic             zero;
   } op_t;

   op_t q[$];
   int  m_cnt = 0;

   function automatic bit ready_exp();
`ifdef EXMEM_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || (mem_ready === 1'b1);
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      bit rdy, pop, push;
      op_t o;
      if (!rst_n) begin
         q.delete();
         m_cnt = 0;
      end else begin
         rdy  = ready_exp();
         pop  = (q.size() > 0) && mem_ready;
         push = ex_valid && rdy;
         if ((q.size() > 0) && !mem_ready && (m_cnt < CNT_MAX)) m_cnt++;
         if (pop) void'(q.pop_front());
         if (push) begin
            o.pc = ex_pc; o.alu = ex_alu_result; o.rs2 = ex_rs2_data;
            o.rd = ex_rd; o.ctrl = ex_ctrl; o.zero = ex_zero;
            q.push_back(o);
         end
         if (flush) q.delete();
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- compare process, away from the active edge ----------------
   always @(negedge clk) begin
      chk("mem_valid", 64'(mem_valid), 64'(q.size() > 0));
      chk("ex_ready",  64'(ex_ready),  64'(ready_exp()));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      if (q.size() > 0) begin
         chk("mem_pc",   mem_pc,               q[0].pc);
         chk("mem_alu",  mem_alu_result,       q[0].alu);
         chk("mem_rs2",  mem_rs2_data,         q[0].rs2);
         chk("mem_rd",   64'(mem_rd),          64'(q[0].rd));
         chk("mem_ctrl", 64'(mem_ctrl),        64'(q[0].ctrl));
         chk("mem_zero", 64'(mem_zero),        64'(q[0].zero));
         chk("br_taken", 64'(mem_branch_taken), 64'(q[0].ctrl[0] & q[0].zero));
      end else begin
         chk("bubble_ctrl", 64'(mem_ctrl), 64'(0));
         chk("bubble_br",   64'(mem_branch_taken), 64'(0));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_payload();
      ex_pc         = {$urandom(), $urandom()};
      ex_alu_result = {$urandom(), $urandom()};
      ex_rs2_data   = {$urandom(), $urandom()};
      ex_rd         = RA_W'($urandom());
      ex_ctrl       = CTRLW'($urandom());
      ex_zero       = 1'($urandom());
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
      rand_payload();
      step(); step();
      chk("rst_valid", 64'(mem_valid), 64'(0));
      chk("rst_cnt",   64'(stall_cnt), 64'(0));
      rst_n = 1'b1;
      #1 chk("rst_ready", 64'(ex_ready), 64'(1));

      // streaming: 8 back-to-back ops
      mem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_payload();
         ex_valid = 1'b1;
         ex_pc    = 64'h100 + 64'(4 * i);
         step();
         chk("stream_pc",    mem_pc, 64'h100 + 64'(4 * i));
         chk("stream_valid", 64'(mem_valid), 64'(1));
      end
      ex_valid = 1'b0;
      step();

      // back-pressure for 3 cycles with input held
      rand_payload();
      ex_valid = 1'b1; ex_pc = 64'h200; mem_ready = 1'b0;
      step();
      ex_pc = 64'h204;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_hold_pc", mem_pc, 64'h200);
         chk("bp_ready",   64'(ex_ready), 64'(0));
      end
      chk("bp_stall3", 64'(stall_cnt), 64'(3));
      mem_ready = 1'b1;
      step();
      chk("bp_next_pc", mem_pc, 64'h204);
      ex_valid = 1'b0;
      step(); step();
      chk("bp_drained", 64'(mem_valid), 64'(0));

      // flush wins over a same-cycle accept
      ex_valid = 1'b1; ex_ctrl = 5'b01010; flush = 1'b1;
      step();
      chk("flush_valid", 64'(mem_valid), 64'(0));
      chk("flush_ctrl",  64'(mem_ctrl),  64'(0));
      flush = 1'b0; ex_valid = 1'b0;

      // branch resolution
      ex_valid = 1'b1; ex_ctrl = 5'b00001; ex_zero = 1'b1;
      step();
      chk("br_taken_1", 64'(mem_branch_taken), 64'(1));
      ex_valid = 1'b0;
      step();
      chk("br_idle_0", 64'(mem_branch_taken), 64'(0));
      ex_valid = 1'b1; ex_zero = 1'b0;
      step();
      chk("br_nz_0", 64'(mem_branch_taken), 64'(0));
      ex_valid = 1'b0;
      step();

      // stall counter saturation (starts at 3, 20 more stalled cycles)
      ex_valid = 1'b1; ex_pc = 64'h300; ex_ctrl = 5'b11111;
      step();
      ex_valid = 1'b0; mem_ready = 1'b0;
      repeat (20) step();
      chk("sat_cnt", 64'(stall_cnt), 64'(15));

      // asynchronous reset mid-cycle with a valid entry held
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(mem_valid), 64'(0));
      chk("arst_ctrl",  64'(mem_ctrl),  64'(0));
      chk("arst_cnt",   64'(stall_cnt), 64'(0));
      rst_n = 1'b1;
      #1 chk("arst_ready", 64'(ex_ready), 64'(1));

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         rand_payload();
         ex_valid  = ($urandom_range(0, 9) < 7);
         mem_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 19) == 0);
         step();
         if ($urandom_range(0, 199) == 0) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end
      flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
